// File: rtl/dl11_multi_uart.sv
// Multi-channel DL11-compatible serial line unit on the DCJ11 EXT I/O bank.
// Each channel has RCSR/RBUF/XCSR/XBUF plus RX/TX FIFOs toward the host link.
module dl11_multi_uart #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned DEPTH = 16,
  parameter logic [21:0] BASE0 = 22'o17777560,
  parameter logic [21:0] BASEN = 22'o17776500
) (
  input  logic             clk_x2,
  input  logic             rstb,
  input  logic             bus_init,
  input  logic [21:0]      bus_addr,
  input  logic             bus_ext,
  input  logic             bus_rd,
  input  logic             bus_wr,
  input  logic             bus_byte,
  input  logic [15:0]      bus_wdata,
  output logic [15:0]      bus_rdata,
  output logic             bus_hit,
  input  logic [8*NCH-1:0] rx_data,
  input  logic [NCH-1:0]   rx_valid,
  output logic [NCH-1:0]   rx_ready,
  output logic [8*NCH-1:0] tx_data,
  output logic [NCH-1:0]   tx_valid,
  input  logic [NCH-1:0]   tx_ready,
  output logic [NCH-1:0]   irq_rx,
  output logic [NCH-1:0]   irq_tx
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {REG_RCSR, REG_RBUF, REG_XCSR, REG_XBUF} reg_e;

  logic [7:0]    rx_mem [NCH][DEPTH];
  logic [7:0]    tx_mem [NCH][DEPTH];
  logic [PW-1:0] rx_wr [NCH];
  logic [PW-1:0] rx_rd [NCH];
  logic [PW-1:0] tx_wr [NCH];
  logic [PW-1:0] tx_rd [NCH];
  logic [7:0]    rx_head [NCH];
  logic [7:0]    tx_head [NCH];

  logic [NCH-1:0] rie, xie, err, ovr;
  logic [NCH-1:0] hit_vec, rx_full, rx_empty, tx_full, tx_empty;
  logic [NCH-1:0] rx_push, rx_pop, tx_push, tx_pop, ovr_set, rbuf_rd;

  reg_e        reg_idx;
  logic        wr_en;
  logic [15:0] rd_val;
  logic [21:0] base;
  logic        unused_wdata;

  assign unused_wdata = ^bus_wdata[15:8];

  always_comb begin
    reg_idx  = reg_e'(bus_addr[2:1]);
    // Odd-byte writes land in the unused high byte of every register.
    wr_en    = bus_wr & ~(bus_byte & bus_addr[0]);
    rd_val   = '0;
    base     = '0;
    hit_vec  = '0;
    rx_full  = '0;
    rx_empty = '0;
    tx_full  = '0;
    tx_empty = '0;
    rx_push  = '0;
    rx_pop   = '0;
    tx_push  = '0;
    tx_pop   = '0;
    ovr_set  = '0;
    rbuf_rd  = '0;
    tx_data  = '0;
    for (int unsigned n = 0; n < NCH; n++) begin
      if (n == 0) base = BASE0;
      else        base = BASEN + 22'(8 * (n - 1));
      hit_vec[n]  = bus_ext && (bus_addr[21:3] == base[21:3]);
      rx_empty[n] = (rx_wr[n] == rx_rd[n]);
      rx_full[n]  = (rx_wr[n][AW] != rx_rd[n][AW]) && (rx_wr[n][AW-1:0] == rx_rd[n][AW-1:0]);
      tx_empty[n] = (tx_wr[n] == tx_rd[n]);
      tx_full[n]  = (tx_wr[n][AW] != tx_rd[n][AW]) && (tx_wr[n][AW-1:0] == tx_rd[n][AW-1:0]);
      rx_head[n]  = rx_empty[n] ? 8'h00 : rx_mem[n][rx_rd[n][AW-1:0]];
      tx_head[n]  = tx_mem[n][tx_rd[n][AW-1:0]];
      tx_data[8*n +: 8] = tx_head[n];

      rbuf_rd[n] = bus_rd & hit_vec[n] & (reg_idx == REG_RBUF);
      rx_pop[n]  = rbuf_rd[n] & ~rx_empty[n];
      rx_push[n] = rx_valid[n] & ~rx_full[n];
      ovr_set[n] = rx_valid[n] & rx_full[n];
      tx_pop[n]  = tx_ready[n] & ~tx_empty[n];
      // A simultaneous host pop frees a slot, so a push into a full FIFO still lands.
      tx_push[n] = wr_en & hit_vec[n] & (reg_idx == REG_XBUF) & (~tx_full[n] | tx_pop[n]);

      if (hit_vec[n]) begin
        case (reg_idx)
          REG_RCSR: rd_val = {8'b0, ~rx_empty[n], rie[n], 6'b0};
          REG_RBUF: rd_val = {err[n], ovr[n], 6'b0, rx_head[n]};
          REG_XCSR: rd_val = {8'b0, ~tx_full[n], xie[n], 6'b0};
          default:  rd_val = '0;
        endcase
      end
    end
  end

  assign bus_hit  = |hit_vec;
  assign rx_ready = ~rx_full;
  assign tx_valid = ~tx_empty;
  assign irq_rx   = rie & ~rx_empty;
  assign irq_tx   = xie & ~tx_full;

  always_ff @(posedge clk_x2) begin
    if (!rstb || bus_init) begin
      bus_rdata <= '0;
      rie       <= '0;
      xie       <= '0;
      err       <= '0;
      ovr       <= '0;
      for (int unsigned n = 0; n < NCH; n++) begin
        rx_wr[n] <= '0;
        rx_rd[n] <= '0;
        tx_wr[n] <= '0;
        tx_rd[n] <= '0;
      end
    end else begin
      if (bus_rd) bus_rdata <= rd_val;
      for (int unsigned n = 0; n < NCH; n++) begin
        if (rx_push[n]) rx_wr[n] <= rx_wr[n] + PW'(1);
        if (rx_pop[n])  rx_rd[n] <= rx_rd[n] + PW'(1);
        if (tx_push[n]) tx_wr[n] <= tx_wr[n] + PW'(1);
        if (tx_pop[n])  tx_rd[n] <= tx_rd[n] + PW'(1);
        // A fresh overrun in the same cycle as an RBUF read stays visible.
        if (ovr_set[n]) begin
          err[n] <= 1'b1;
          ovr[n] <= 1'b1;
        end else if (rbuf_rd[n]) begin
          err[n] <= 1'b0;
          ovr[n] <= 1'b0;
        end
        if (wr_en && hit_vec[n]) begin
          if (reg_idx == REG_RCSR) rie[n] <= bus_wdata[6];
          if (reg_idx == REG_XCSR) xie[n] <= bus_wdata[6];
        end
      end
    end
  end

  always_ff @(posedge clk_x2) begin
    for (int unsigned n = 0; n < NCH; n++) begin
      if (rx_push[n]) rx_mem[n][rx_wr[n][AW-1:0]] <= rx_data[8*n +: 8];
      if (tx_push[n]) tx_mem[n][tx_wr[n][AW-1:0]] <= bus_wdata[7:0];
    end
  end

endmodule

// File: tb/tb_dl11_multi_uart.sv
// Directed bench for dl11_multi_uart: register access, FIFO flow, overflow and init.
module tb_dl11_multi_uart;

  localparam int unsigned NCH   = 2;
  localparam int unsigned DEPTH = 16;
  localparam logic [21:0] CH0   = 22'o17777560;
  localparam logic [21:0] CH1   = 22'o17776500;

  logic             clk_x2 = 1'b0;
  logic             rstb;
  logic             bus_init;
  logic [21:0]      bus_addr;
  logic             bus_ext;
  logic             bus_rd;
  logic             bus_wr;
  logic             bus_byte;
  logic [15:0]      bus_wdata;
  logic [15:0]      bus_rdata;
  logic             bus_hit;
  logic [8*NCH-1:0] rx_data;
  logic [NCH-1:0]   rx_valid;
  logic [NCH-1:0]   rx_ready;
  logic [8*NCH-1:0] tx_data;
  logic [NCH-1:0]   tx_valid;
  logic [NCH-1:0]   tx_ready;
  logic [NCH-1:0]   irq_rx;
  logic [NCH-1:0]   irq_tx;

  int n_checks = 0;
  int n_errors = 0;

  dl11_multi_uart #(.NCH(NCH), .DEPTH(DEPTH), .BASE0(CH0), .BASEN(CH1)) dut (
    .clk_x2(clk_x2), .rstb(rstb), .bus_init(bus_init), .bus_addr(bus_addr),
    .bus_ext(bus_ext), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_byte(bus_byte),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_hit(bus_hit),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .irq_rx(irq_rx), .irq_tx(irq_tx)
  );

  always #5 clk_x2 = ~clk_x2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_read(input logic [21:0] a, output logic [15:0] d);
    @(negedge clk_x2);
    bus_addr = a;
    bus_ext  = 1'b1;
    bus_rd   = 1'b1;
    @(negedge clk_x2);
    bus_rd   = 1'b0;
    bus_ext  = 1'b0;
    d        = bus_rdata;
  endtask

  task automatic bus_write(input logic [21:0] a, input logic [15:0] d, input logic b);
    @(negedge clk_x2);
    bus_addr  = a;
    bus_ext   = 1'b1;
    bus_wr    = 1'b1;
    bus_byte  = b;
    bus_wdata = d;
    @(negedge clk_x2);
    bus_wr    = 1'b0;
    bus_ext   = 1'b0;
    bus_byte  = 1'b0;
  endtask

  task automatic host_send(input int ch, input logic [7:0] b);
    @(negedge clk_x2);
    rx_data[8*ch +: 8] = b;
    rx_valid[ch]       = 1'b1;
    @(negedge clk_x2);
    rx_valid[ch]       = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] d;
    int          got;

    rstb = 1'b0; bus_init = 1'b0; bus_addr = '0; bus_ext = 1'b0;
    bus_rd = 1'b0; bus_wr = 1'b0; bus_byte = 1'b0; bus_wdata = '0;
    rx_data = '0; rx_valid = '0; tx_ready = '0;
    repeat (3) @(negedge clk_x2);
    check("reset_rdata", 32'(bus_rdata), 32'h0);
    check("reset_txv", 32'(tx_valid), 32'h0);
    check("reset_rxrdy", 32'(rx_ready), 32'h3);
    check("reset_irq", 32'({irq_rx, irq_tx}), 32'h0);
    rstb = 1'b1;

    // Address decode
    @(negedge clk_x2);
    bus_addr = CH1 + 22'd4; bus_ext = 1'b1; #1;
    check("hit_ch1", 32'(bus_hit), 32'h1);
    bus_ext = 1'b0; #1;
    check("hit_noext", 32'(bus_hit), 32'h0);
    bus_addr = CH1 + 22'd8; bus_ext = 1'b1; #1;
    check("hit_ch2_absent", 32'(bus_hit), 32'h0);
    bus_ext = 1'b0;

    // 1: idle CSRs
    bus_read(CH0 + 22'd4, d); check("t1_xcsr", 32'(d), 32'o200);
    bus_read(CH0 + 22'd0, d); check("t1_rcsr", 32'(d), 32'o0);

    // 2: two host bytes on ch0
    host_send(0, 8'h41);
    host_send(0, 8'h42);
    bus_read(CH0 + 22'd0, d); check("t2_rcsr_done", 32'(d), 32'o200);
    bus_read(CH0 + 22'd2, d); check("t2_rbuf0", 32'(d), 32'h0041);
    bus_read(CH0 + 22'd2, d); check("t2_rbuf1", 32'(d), 32'h0042);
    bus_read(22'o17777000, d); check("t2_nohit_rd", 32'(d), 32'h0);
    bus_read(CH0 + 22'd0, d); check("t2_rcsr_empty", 32'(d), 32'o0);
    bus_read(CH0 + 22'd2, d); check("t2_rbuf_empty", 32'(d), 32'h0);

    // 3: RIE on ch1
    bus_write(CH1 + 22'd0, 16'o100, 1'b0);
    check("t3_irq_idle", 32'(irq_rx), 32'h0);
    host_send(1, 8'h55);
    check("t3_irq_set", 32'(irq_rx), 32'h2);
    bus_read(CH1 + 22'd0, d); check("t3_rcsr1", 32'(d), 32'o300);
    bus_read(CH1 + 22'd2, d); check("t3_rbuf1", 32'(d), 32'h0055);
    check("t3_irq_clr", 32'(irq_rx), 32'h0);

    // 4: fill TX with host stalled
    tx_ready = '0;
    for (int i = 0; i < 17; i++) begin
      bus_write(CH0 + 22'd6, 16'(i), 1'b0);
      if (i == 15) begin
        bus_read(CH0 + 22'd4, d);
        check("t4_rdy_full", 32'(d), 32'o0);
      end
    end
    check("t4_txv0", 32'(tx_valid), 32'h1);
    @(negedge clk_x2);
    tx_ready[0] = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 16; c++) begin
      if (tx_valid[0]) begin
        check("t4_txbyte", 32'(tx_data[7:0]), 32'(got));
        got++;
      end
      @(negedge clk_x2);
    end
    check("t4_txcount", 32'(got), 32'd16);
    check("t4_txdrained", 32'(tx_valid), 32'h0);
    tx_ready = '0;
    bus_read(CH0 + 22'd4, d); check("t4_rdy_back", 32'(d), 32'o200);

    // XIE: odd-byte write is ignored, word write takes effect
    bus_write(CH0 + 22'd5, 16'o100, 1'b1);
    check("xie_oddbyte", 32'(irq_tx), 32'h0);
    bus_write(CH0 + 22'd4, 16'o100, 1'b0);
    check("xie_word", 32'(irq_tx), 32'h1);
    bus_read(CH0 + 22'd4, d); check("xcsr_xie", 32'(d), 32'o300);
    bus_write(CH0 + 22'd4, 16'o000, 1'b0);
    check("xie_clr", 32'(irq_tx), 32'h0);

    // 5: RX overflow on ch0
    for (int i = 0; i < 17; i++) begin
      host_send(0, 8'(i));
      if (i == 15) check("t5_rxrdy_full", 32'(rx_ready), 32'h2);
    end
    bus_read(CH0 + 22'd2, d); check("t5_rbuf_ovr", 32'(d), 32'o140000);
    check("t5_rxrdy_back", 32'(rx_ready), 32'h3);
    bus_read(CH0 + 22'd2, d); check("t5_rbuf_clr", 32'(d), 32'h0001);

    // 6: bus_init with IE set and both FIFOs partly filled
    bus_write(CH0 + 22'd0, 16'o100, 1'b0);
    bus_write(CH0 + 22'd4, 16'o100, 1'b0);
    for (int i = 0; i < 8; i++) bus_write(CH0 + 22'd6, 16'(8'hA0 + i), 1'b0);
    check("t6_pre_irq", 32'({irq_rx, irq_tx}), 32'h5);
    check("t6_pre_txv", 32'(tx_valid), 32'h1);
    @(negedge clk_x2);
    bus_init = 1'b1;
    @(negedge clk_x2);
    bus_init = 1'b0;
    check("t6_txv", 32'(tx_valid), 32'h0);
    check("t6_rdata", 32'(bus_rdata), 32'h0);
    check("t6_irq", 32'({irq_rx, irq_tx}), 32'h0);
    check("t6_rxrdy", 32'(rx_ready), 32'h3);
    bus_read(CH0 + 22'd0, d); check("t6_rcsr", 32'(d), 32'o0);
    bus_read(CH0 + 22'd4, d); check("t6_xcsr", 32'(d), 32'o200);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
